// File: rtl/gb_video_pkg.sv
// Shared Game Boy video constants and pixel types for the LCD scaler.
// Latency: n/a (types, constants and a pure combinational helper only).
// Backpressure: n/a.
package gb_video_pkg;

    // Game Boy LCD geometry and frame buffer size
    localparam int GB_W     = 160;
    localparam int GB_H     = 144;
    localparam int FB_DEPTH = GB_W * GB_H;        // 23040 shades
    localparam int FB_AW    = $clog2(FB_DEPTH);   // 15-bit addresses
    localparam int SCALE    = 3;

    // 640x480@60 output raster
    localparam int H_TOTAL  = 800;
    localparam int V_TOTAL  = 525;
    localparam int H_ACT    = 640;
    localparam int V_ACT    = 480;

    typedef logic [1:0]  shade_t;
    typedef logic [14:0] rgb555_t;

    // Four-entry palette lookup; shade 0 is the lightest.
    function automatic rgb555_t shade_to_rgb(
        input shade_t  s,
        input rgb555_t p0,
        input rgb555_t p1,
        input rgb555_t p2,
        input rgb555_t p3
    );
        rgb555_t c;
        case (s)
            2'd0:    c = p0;
            2'd1:    c = p1;
            2'd2:    c = p2;
            default: c = p3;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/gb_fb_ram.sv
// Simple dual-port frame buffer RAM, synchronous write, registered read-first.
// Latency: read data valid 1 cycle after i_re; same-address write returns old data.
// Backpressure: none, both ports accept every cycle.
// Ports: i_clk; write port i_we/i_waddr/i_wdata; read port i_re/i_raddr -> o_rdata.
module gb_fb_ram #(
    parameter int DEPTH = 23040,
    parameter int WIDTH = 2,
    parameter int AW    = 15
) (
    input  logic             i_clk,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    // No reset on the array or the read register so this maps onto block RAM.
    // Non-blocking update of both gives read-first behaviour on collisions.
    always_ff @(posedge i_clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
        if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/gb_lcd_scaler.sv
// Captures the 160x144 PPU shade stream and replays it 3x-scaled, centred, as RGB555.
// Latency: pix_data reflects pos_x/pos_y presented exactly 2 cycles earlier.
// Backpressure: none; PPU pixels past a full frame without vsync are dropped and flagged.
// Ports: clk25_2/reset_n; PPU side px_valid/px_data/px_vsync; raster pos_x/pos_y;
//        outputs pix_data (RGB555) and sticky err_overflow.
module gb_lcd_scaler
    import gb_video_pkg::*;
#(
    parameter int      H_OFF  = 80,
    parameter int      V_OFF  = 24,
    parameter rgb555_t PAL0   = 15'h7FFF,
    parameter rgb555_t PAL1   = 15'h56B5,
    parameter rgb555_t PAL2   = 15'h294A,
    parameter rgb555_t PAL3   = 15'h0000,
    parameter rgb555_t BORDER = 15'h0000
) (
    input  logic        clk25_2,
    input  logic        reset_n,
    input  logic        px_valid,
    input  logic [1:0]  px_data,
    input  logic        px_vsync,
    input  logic [9:0]  pos_x,
    input  logic [9:0]  pos_y,
    output logic [14:0] pix_data,
    output logic        err_overflow
);

    localparam logic [9:0]       X_PRE      = 10'(H_OFF - 1);
    localparam logic [9:0]       X_FIRST    = 10'(H_OFF);
    localparam logic [9:0]       X_END      = 10'(H_OFF + GB_W * SCALE);
    localparam logic [9:0]       Y_PRE      = 10'(V_OFF - 1);
    localparam logic [9:0]       Y_FIRST    = 10'(V_OFF);
    localparam logic [9:0]       Y_END      = 10'(V_OFF + GB_H * SCALE);
    localparam logic [9:0]       X_LINE_END = 10'(H_TOTAL - 1);
    localparam logic [1:0]       SUB_LAST   = 2'(SCALE - 1);
    localparam logic [FB_AW-1:0] FB_END     = FB_AW'(FB_DEPTH);
    localparam logic [FB_AW-1:0] LINE_STEP  = FB_AW'(GB_W);

    // ---------------------------------------------------------------
    // Write side: PPU stream into the frame buffer
    // ---------------------------------------------------------------
    logic [FB_AW-1:0] r_wr_addr;
    logic             r_err_overflow;
    logic             w_we;
    logic [FB_AW-1:0] w_waddr;

    // A vsync with a pixel in the same cycle writes that pixel at address 0.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_wr_addr;
        if (px_vsync) begin
            w_we    = px_valid;
            w_waddr = '0;
        end else if (px_valid && (r_wr_addr < FB_END)) begin
            w_we = 1'b1;
        end
    end

    always_ff @(posedge clk25_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_addr      <= '0;
            r_err_overflow <= 1'b0;
        end else if (px_vsync) begin
            r_wr_addr <= px_valid ? FB_AW'(1) : '0;
        end else if (px_valid) begin
            if (r_wr_addr < FB_END) begin
                r_wr_addr <= r_wr_addr + 1'b1;
            end else begin
                // Frame overrun: hold the pointer, drop the pixel, latch the error
                r_err_overflow <= 1'b1;
            end
        end
    end

    // ---------------------------------------------------------------
    // Read side: incremental source coordinate tracking
    // ---------------------------------------------------------------
    logic             w_x_in;
    logic             w_y_in;
    logic             w_in_win;
    logic [7:0]       r_src_x;
    logic [1:0]       r_sub_x;
    logic [1:0]       r_sub_y;
    logic [FB_AW-1:0] r_line_base;
    logic [FB_AW-1:0] w_rd_addr;

    assign w_x_in   = (pos_x >= X_FIRST) && (pos_x < X_END);
    assign w_y_in   = (pos_y >= Y_FIRST) && (pos_y < Y_END);
    assign w_in_win = w_x_in && w_y_in;

    // src_x/sub_x always describe the position currently on pos_x; they are
    // primed one column early so the first window column already reads src 0.
    // src_x runs to 160 on the last window column but is never used there.
    always_ff @(posedge clk25_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_src_x <= '0;
            r_sub_x <= '0;
        end else if (pos_x == X_PRE) begin
            r_src_x <= '0;
            r_sub_x <= '0;
        end else if (w_x_in) begin
            if (r_sub_x == SUB_LAST) begin
                r_sub_x <= '0;
                r_src_x <= r_src_x + 1'b1;
            end else begin
                r_sub_x <= r_sub_x + 1'b1;
            end
        end
    end

    // Row tracking advances at the end of each line, for the row that follows.
    always_ff @(posedge clk25_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_sub_y     <= '0;
            r_line_base <= '0;
        end else if (pos_x == X_LINE_END) begin
            if (pos_y == Y_PRE) begin
                r_sub_y     <= '0;
                r_line_base <= '0;
            end else if (w_y_in) begin
                if (r_sub_y == SUB_LAST) begin
                    r_sub_y     <= '0;
                    r_line_base <= r_line_base + LINE_STEP;
                end else begin
                    r_sub_y <= r_sub_y + 1'b1;
                end
            end
        end
    end

    assign w_rd_addr = r_line_base + FB_AW'(r_src_x);

    // ---------------------------------------------------------------
    // Frame buffer
    // ---------------------------------------------------------------
    shade_t w_shade;

    gb_fb_ram #(
        .DEPTH (FB_DEPTH),
        .WIDTH (2),
        .AW    (FB_AW)
    ) u_fb_ram (
        .i_clk   (clk25_2),
        .i_we    (w_we),
        .i_waddr (w_waddr),
        .i_wdata (px_data),
        .i_re    (w_in_win),
        .i_raddr (w_rd_addr),
        .o_rdata (w_shade)
    );

    // ---------------------------------------------------------------
    // Output pipeline: window flag follows the RAM read by one stage
    // ---------------------------------------------------------------
    logic    r_in_win_d;
    rgb555_t r_pix_data;
    rgb555_t w_pal;

    assign w_pal = shade_to_rgb(w_shade, PAL0, PAL1, PAL2, PAL3);

    always_ff @(posedge clk25_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_in_win_d <= 1'b0;
            r_pix_data <= '0;
        end else begin
            r_in_win_d <= w_in_win;
            r_pix_data <= r_in_win_d ? w_pal : BORDER;
        end
    end

    assign pix_data     = r_pix_data;
    assign err_overflow = r_err_overflow;

endmodule
